// File: rtl/matmul_result_drain_pkg.sv
// -----------------------------------------------------------------------------
// matmul_drain_pkg
// Shared types and helpers for the matmul result drain block.
//   drain_state_e : drain FSM state encoding (IDLE, DRAIN)
//   TILE_CNT_W    : width of the drained-tile counter
//   sat_narrow()  : clamps a signed value into an out_p-bit signed range and
//                   reports whether clamping happened. Only the narrowing stage
//                   calls it, and only when MATMUL_DRAIN_SATURATE_EN is defined.
// -----------------------------------------------------------------------------
package matmul_drain_pkg;

    localparam int TILE_CNT_W = 16;

    // Working width for the clamp helper; wide enough for any 4*P input.
    localparam int NARROW_W = 64;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic signed [NARROW_W-1:0] value;
        logic                       clamp;
    } sat_result_t;

    function automatic sat_result_t sat_narrow(input logic signed [NARROW_W-1:0] value,
                                               input int out_p);
        logic signed [NARROW_W-1:0] hi;
        logic signed [NARROW_W-1:0] lo;
        sat_result_t r;
        hi      = (64'sd1 <<< (out_p - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (out_p - 1));
        r.value = value;
        r.clamp = 1'b0;
        // A full-width target cannot overflow, so it is never clamped.
        if (out_p < NARROW_W) begin
            if (value > hi) begin
                r.value = hi;
                r.clamp = 1'b1;
            end else if (value < lo) begin
                r.value = lo;
                r.clamp = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/matmul_result_drain_if.sv
// -----------------------------------------------------------------------------
// matmul_result_drain_if
// Bundles the tile input handshake and the row output stream of the drain.
//   D_in/valid_in/ready_in            : tile from the MAC stage
//   data_out/row_out/last_out/
//   valid_out/ready_out               : row stream toward the consumer
// Modports: slave = the drain block, master = its environment (producer and
// consumer together).
// -----------------------------------------------------------------------------
interface matmul_result_drain_if #(
    parameter int M     = 2,
    parameter int N     = 2,
    parameter int P     = 8,
    parameter int OUT_P = 16
);
    localparam int ROW_W = (M > 1) ? $clog2(M) : 1;

    logic [M-1:0][N-1:0][4*P-1:0] D_in;
    logic                         valid_in;
    logic                         ready_in;
    logic [N-1:0][OUT_P-1:0]      data_out;
    logic [ROW_W-1:0]             row_out;
    logic                         last_out;
    logic                         valid_out;
    logic                         ready_out;

    modport slave (
        input  D_in, valid_in, ready_out,
        output ready_in, data_out, row_out, last_out, valid_out
    );

    modport master (
        output D_in, valid_in, ready_out,
        input  ready_in, data_out, row_out, last_out, valid_out
    );

endinterface

// File: rtl/matmul_result_drain_narrow.sv
// -----------------------------------------------------------------------------
// drain_narrow
// Combinational narrowing of one row of N signed elements from IN_W to OUT_W.
//   row_i       : N x IN_W input elements (two's complement)
//   row_o       : N x OUT_W narrowed elements
//   clamp_any_o : high when any element of the row was clamped
// Build option MATMUL_DRAIN_SATURATE_EN: when defined each element is clamped
// to the OUT_W signed range; otherwise the low OUT_W bits are kept and
// clamp_any_o is constant 0.
// -----------------------------------------------------------------------------
module drain_narrow
    import matmul_drain_pkg::*;
#(
    parameter int N     = 2,
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic [N-1:0][IN_W-1:0]  row_i,
    output logic [N-1:0][OUT_W-1:0] row_o,
    output logic                    clamp_any_o
);

    logic [N-1:0] clamp;

    for (genvar gi = 0; gi < N; gi++) begin : g_elem
`ifdef MATMUL_DRAIN_SATURATE_EN
        sat_result_t sat_r;
        logic        unused_bits;
        assign sat_r       = sat_narrow(NARROW_W'($signed(row_i[gi])), OUT_W);
        assign row_o[gi]   = sat_r.value[OUT_W-1:0];
        assign clamp[gi]   = sat_r.clamp;
        // Upper bits of the clamped value are pure sign extension.
        assign unused_bits = ^sat_r.value;
`else
        logic unused_bits;
        assign row_o[gi]   = row_i[gi][OUT_W-1:0];
        assign clamp[gi]   = 1'b0;
        // Bits above OUT_W are dropped by truncation.
        assign unused_bits = ^row_i[gi];
`endif
    end

    assign clamp_any_o = |clamp;

endmodule

// File: rtl/matmul_result_drain.sv
// -----------------------------------------------------------------------------
// matmul_result_drain
// Buffers up to BUFFERS result tiles (M x N, 4*P-bit signed) from the MAC
// stage in a ping-pong register bank and streams each tile out one row of N
// elements per beat, narrowed to OUT_P bits.
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset; drops all pending tiles
//   bus        : slave side of matmul_result_drain_if (tile in, row stream out)
//   tile_cnt_o : number of tiles fully drained, wraps at 2^16
//   sat_o      : sticky flag, set by an accepted beat containing a clamped
//                element (only with MATMUL_DRAIN_SATURATE_EN; else 0)
// Build option MATMUL_DRAIN_SATURATE_EN selects saturating narrowing.
// Interface parameters must match this module's M, N, P, OUT_P.
// -----------------------------------------------------------------------------
module matmul_result_drain
    import matmul_drain_pkg::*;
#(
    parameter int M       = 2,
    parameter int N       = 2,
    parameter int P       = 8,
    parameter int OUT_P   = 16,
    parameter int BUFFERS = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    matmul_result_drain_if.slave  bus,
    output logic [TILE_CNT_W-1:0] tile_cnt_o,
    output logic                  sat_o
);

    localparam int IN_W  = 4 * P;
    localparam int ROW_W = (M > 1) ? $clog2(M) : 1;

    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_DRAIN = DRAIN;

    typedef logic [M-1:0][N-1:0][IN_W-1:0] tile_t;

    // Two slots are always declared; with BUFFERS = 1 slot 1 is never
    // written and both pointers stay at 0.
    tile_t                 bank_q [2];
    logic [1:0]            bank_full_q, bank_full_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [0:0]            state_q, state_d;
    logic [TILE_CNT_W-1:0] tile_cnt_q, tile_cnt_d;

    logic                    ready_in_w;
    logic                    accept;
    logic                    draining;
    logic                    beat;
    logic                    last_row;
    logic                    tile_done;
    logic                    other_full;
    tile_t                   rd_tile;
    logic [N-1:0][OUT_P-1:0] row_narrow;
    logic                    clamp_any;

    // ready_in depends only on registered state, so the producer never sees
    // a combinational path from the consumer side.
    assign ready_in_w   = !bank_full_q[wr_bank_q];
    assign accept       = bus.valid_in & ready_in_w;
    assign draining     = (state_q == S_DRAIN);
    assign beat         = draining & bus.ready_out;
    assign last_row     = (row_q == ROW_W'(M - 1));
    assign tile_done    = beat & last_row;
    assign other_full   = (BUFFERS == 2) ? bank_full_q[~rd_bank_q] : 1'b0;

    always_comb begin
        bank_full_d = bank_full_q;
        // Release first, then accept: the two always target different slots
        // because ready_in blocks a write into a full slot.
        if (tile_done) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
        if (accept) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end

        wr_bank_d = (accept && BUFFERS == 2) ? ~wr_bank_q : wr_bank_q;
        rd_bank_d = (tile_done && BUFFERS == 2) ? ~rd_bank_q : rd_bank_q;

        row_d = row_q;
        if (beat) begin
            row_d = last_row ? '0 : row_q + ROW_W'(1);
        end

        tile_cnt_d = tile_cnt_q + TILE_CNT_W'(tile_done);

        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                if (tile_done) begin
                    state_d = other_full ? S_DRAIN : S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bank_full_q <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            row_q       <= '0;
            state_q     <= S_IDLE;
            tile_cnt_q  <= '0;
        end else begin
            bank_full_q <= bank_full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            row_q       <= row_d;
            state_q     <= state_d;
            tile_cnt_q  <= tile_cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < 2; b++) begin
                bank_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (b < BUFFERS && accept && wr_bank_q == 1'(b)) begin
                    bank_q[b] <= bus.D_in;
                end
            end
        end
    end

    // The slot being read is full and cannot be rewritten until released,
    // so the presented row stays stable under backpressure.
    assign rd_tile = bank_q[rd_bank_q];

`ifdef MATMUL_DRAIN_SATURATE_EN
    drain_narrow #(
        .N     (N),
        .IN_W  (IN_W),
        .OUT_W (OUT_P)
    ) u_narrow (
        .row_i       (rd_tile[row_q]),
        .row_o       (row_narrow),
        .clamp_any_o (clamp_any)
    );

    logic sat_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sat_q <= 1'b0;
        end else if (beat && clamp_any) begin
            sat_q <= 1'b1;
        end
    end
    assign sat_o = sat_q;
`else
    logic clamp_unused;
    drain_narrow #(
        .N     (N),
        .IN_W  (IN_W),
        .OUT_W (OUT_P)
    ) u_narrow (
        .row_i       (rd_tile[row_q]),
        .row_o       (row_narrow),
        .clamp_any_o (clamp_unused)
    );
    assign clamp_any = 1'b0;
    assign sat_o     = clamp_any;
`endif

    assign bus.ready_in  = ready_in_w;
    assign bus.valid_out = draining;
    assign bus.data_out  = draining ? row_narrow : '0;
    assign bus.row_out   = draining ? row_q : '0;
    assign bus.last_out  = draining & last_row;
    assign tile_cnt_o    = tile_cnt_q;

endmodule

// File: tb/tb_matmul_result_drain.sv
// Directed bench for matmul_result_drain with M = N = 2, P = 8, OUT_P = 16,
// BUFFERS = 2. Expected values are written out by hand per step.
module tb_matmul_result_drain;
    import matmul_drain_pkg::*;

    logic                  clk;
    logic                  rst;
    logic [TILE_CNT_W-1:0] tile_cnt;
    logic                  sat;

    int checks   = 0;
    int failures = 0;

`ifdef MATMUL_DRAIN_SATURATE_EN
    localparam logic [15:0] BIG_POS = 16'h7FFF;
    localparam logic [15:0] BIG_NEG = 16'h8000;
    localparam logic        SAT_EXP = 1'b1;
`else
    localparam logic [15:0] BIG_POS = 16'd4464;
    localparam logic [15:0] BIG_NEG = 16'hEE90;
    localparam logic        SAT_EXP = 1'b0;
`endif

    matmul_result_drain_if #(.M(2), .N(2), .P(8), .OUT_P(16)) bus ();

    matmul_result_drain #(
        .M(2), .N(2), .P(8), .OUT_P(16), .BUFFERS(2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .tile_cnt_o (tile_cnt),
        .sat_o      (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] row_val(input int a, input int b);
        logic [31:0] r;
        r = {16'(b), 16'(a)};
        return 64'(r);
    endfunction

    task automatic set_tile(input int a, input int b, input int c, input int d);
        bus.D_in[0][0] = 32'(a);
        bus.D_in[0][1] = 32'(b);
        bus.D_in[1][0] = 32'(c);
        bus.D_in[1][1] = 32'(d);
    endtask

    task automatic expect_row(input string tag, input int a, input int b,
                              input int row, input logic last);
        check({tag, "_valid"}, 64'(bus.valid_out), 64'd1);
        check({tag, "_data"},  64'(bus.data_out), row_val(a, b));
        check({tag, "_row"},   64'(bus.row_out), 64'(row));
        check({tag, "_last"},  64'(bus.last_out), 64'(last));
        $display("beat %s data=%0h row=%0d last=%0d", tag, bus.data_out, bus.row_out, bus.last_out);
    endtask

    initial begin
        rst           = 1'b1;
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b0;
        bus.D_in      = '0;

        // Reset state
        #2;
        check("rst_valid_out", 64'(bus.valid_out), 64'd0);
        check("rst_last_out",  64'(bus.last_out), 64'd0);
        check("rst_row_out",   64'(bus.row_out), 64'd0);
        check("rst_data_out",  64'(bus.data_out), 64'd0);
        check("rst_tile_cnt",  64'(tile_cnt), 64'd0);
        check("rst_sat",       64'(sat), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("idle_ready_in",  64'(bus.ready_in), 64'd1);
        check("idle_valid_out", 64'(bus.valid_out), 64'd0);
        tick();
        check("idle_valid_out2", 64'(bus.valid_out), 64'd0);

        // Single tile at full rate
        set_tile(1, 2, 3, 4);
        bus.valid_in  = 1'b1;
        bus.ready_out = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        check("t1_latency_valid", 64'(bus.valid_out), 64'd0);
        tick();
        expect_row("t1_r0", 1, 2, 0, 1'b0);
        check("t1_cnt_mid", 64'(tile_cnt), 64'd0);
        tick();
        expect_row("t1_r1", 3, 4, 1, 1'b1);
        tick();
        check("t1_done_valid", 64'(bus.valid_out), 64'd0);
        check("t1_tile_cnt",   64'(tile_cnt), 64'd1);

        // Three tiles offered back-to-back under backpressure
        bus.ready_out = 1'b0;
        set_tile(10, 11, 12, 13);
        bus.valid_in = 1'b1;
        check("bb_ready_a", 64'(bus.ready_in), 64'd1);
        tick();
        set_tile(20, 21, 22, 23);
        check("bb_ready_b", 64'(bus.ready_in), 64'd1);
        tick();
        set_tile(30, 31, 32, 33);
        check("bb_ready_c_blocked", 64'(bus.ready_in), 64'd0);
        expect_row("bb_a_r0", 10, 11, 0, 1'b0);
        tick();
        expect_row("bb_a_r0_hold", 10, 11, 0, 1'b0);
        check("bb_ready_c_blocked2", 64'(bus.ready_in), 64'd0);
        bus.ready_out = 1'b1;
        tick();
        expect_row("bb_a_r1", 12, 13, 1, 1'b1);
        check("bb_ready_c_blocked3", 64'(bus.ready_in), 64'd0);
        tick();
        expect_row("bb_b_r0", 20, 21, 0, 1'b0);
        check("bb_ready_c_free", 64'(bus.ready_in), 64'd1);
        check("bb_cnt2", 64'(tile_cnt), 64'd2);
        tick();
        bus.valid_in = 1'b0;
        expect_row("bb_b_r1", 22, 23, 1, 1'b1);
        check("bb_ready_full_again", 64'(bus.ready_in), 64'd0);
        tick();
        expect_row("bb_c_r0", 30, 31, 0, 1'b0);
        check("bb_cnt3", 64'(tile_cnt), 64'd3);
        tick();
        expect_row("bb_c_r1", 32, 33, 1, 1'b1);
        tick();
        check("bb_done_valid", 64'(bus.valid_out), 64'd0);
        check("bb_cnt4", 64'(tile_cnt), 64'd4);

        // ready_out pattern 1,0,0,1 during a drain
        bus.ready_out = 1'b0;
        set_tile(40, 41, 42, 43);
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        tick();
        expect_row("bp_r0", 40, 41, 0, 1'b0);
        bus.ready_out = 1'b1;
        tick();
        expect_row("bp_r1", 42, 43, 1, 1'b1);
        bus.ready_out = 1'b0;
        tick();
        expect_row("bp_r1_stall1", 42, 43, 1, 1'b1);
        tick();
        expect_row("bp_r1_stall2", 42, 43, 1, 1'b1);
        check("bp_cnt_stalled", 64'(tile_cnt), 64'd4);
        bus.ready_out = 1'b1;
        tick();
        check("bp_done_valid", 64'(bus.valid_out), 64'd0);
        check("bp_cnt5", 64'(tile_cnt), 64'd5);

        // Narrowing of out-of-range elements
        set_tile(70000, -70000, 5, -5);
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        tick();
        check("nr_r0_data", 64'(bus.data_out), 64'({BIG_NEG, BIG_POS}));
        check("nr_sat_before_beat", 64'(sat), 64'd0);
        $display("beat nr_r0 data=%0h sat=%0d", bus.data_out, sat);
        tick();
        expect_row("nr_r1", 5, -5, 1, 1'b1);
        check("nr_sat_after_beat", 64'(sat), 64'(SAT_EXP));
        tick();
        check("nr_sat_sticky", 64'(sat), 64'(SAT_EXP));
        check("nr_cnt6", 64'(tile_cnt), 64'd6);

        // Reset with tile A on row 1 and tile B buffered
        bus.ready_out = 1'b0;
        set_tile(50, 51, 52, 53);
        bus.valid_in = 1'b1;
        tick();
        set_tile(60, 61, 62, 63);
        tick();
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b1;
        tick();
        bus.ready_out = 1'b0;
        expect_row("rs_a_r1_pending", 52, 53, 1, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rs_valid_now",  64'(bus.valid_out), 64'd0);
        check("rs_data_now",   64'(bus.data_out), 64'd0);
        check("rs_cnt_now",    64'(tile_cnt), 64'd0);
        check("rs_sat_now",    64'(sat), 64'd0);
        #3 rst = 1'b0;
        bus.ready_out = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rs_post_valid_%0d", i), 64'(bus.valid_out), 64'd0);
            check($sformatf("rs_post_ready_%0d", i), 64'(bus.ready_in), 64'd1);
        end
        check("rs_post_cnt", 64'(tile_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
